ram_bist_p: RTL and testbench

- Built-in self-test initiator for the parameterised single-port synchronous RAM (`ram_p`). Drives the RAM's clock-domain ports the way a bench would, but in hardware.
- Test sequence: writes a pattern to every address, reads it back and compares. Then repeats with the inverted pattern.
- Reports pass, or the first failing address with expected and actual data.
- Sits beside `ram_p`: its `mem_*` outputs connect to the RAM's `write_enable`, `address` and `data_in`; the RAM's `data_out` feeds `mem_data_in`.

---
 rtl/ram_bist_p.sv | 103 ++++++++++
 tb/tb_ram_bist_p.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ram_bist_p.sv
// ram_bist_p: march-style BIST initiator writing P0/P1 patterns to ram_p and checking readback
// Ports: clock/reset_n (async active-low); start begins a test; busy/done/pass report status;
// fail_address/fail_expected/fail_actual hold the first mismatch; mem_* drive ram_p and
// mem_data_in returns its data_out (one-cycle read latency).
module ram_bist_p #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_address,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR0  = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_RD1  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_FAIL = 3'd6;
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [DATA_WIDTH-1:0] pipe_exp;
  logic                  pipe_valid;
  logic                  drain;
  logic                  wr, rd, inv, last, mismatch;
  logic [DATA_WIDTH-1:0] pattern;
  always_comb begin
    wr       = (state == S_WR0) || (state == S_WR1);
    rd       = (state == S_RD0) || (state == S_RD1);
    inv      = (state == S_WR1) || (state == S_RD1);
    last     = &cnt;
    pattern  = inv ? ~DATA_WIDTH'(cnt) : DATA_WIDTH'(cnt);
    mismatch = rd && pipe_valid && (mem_data_in != pipe_exp);
    busy             = wr || rd;
    done             = (state == S_DONE) || (state == S_FAIL);
    pass             = state == S_DONE;
    mem_write_enable = wr;
    mem_address      = (wr || rd) ? cnt : '0;
    mem_data_out     = wr ? pattern : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pipe_addr     <= '0;
      pipe_exp      <= '0;
      pipe_valid    <= 1'b0;
      drain         <= 1'b0;
      fail_address  <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state         <= S_WR0;
            cnt           <= '0;
            fail_address  <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
          end
        end
        S_WR0, S_WR1: begin
          cnt <= cnt + 1'b1;
          if (last) state <= (state == S_WR0) ? S_RD0 : S_RD1;
        end
        S_RD0, S_RD1: begin
          // one-deep pipe: the word issued this cycle is compared next cycle
          pipe_valid <= !drain;
          pipe_addr  <= cnt;
          pipe_exp   <= pattern;
          if (!drain) begin
            cnt <= cnt + 1'b1;
            if (last) drain <= 1'b1;
          end
          if (mismatch) begin
            state         <= S_FAIL;
            pipe_valid    <= 1'b0;
            drain         <= 1'b0;
            fail_address  <= pipe_addr;
            fail_expected <= pipe_exp;
            fail_actual   <= mem_data_in;
          end else if (drain) begin
            drain <= 1'b0;
            state <= (state == S_RD0) ? S_WR1 : S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_bist_p.sv
// tb_ram_bist_p: self-checking bench for ram_bist_p with a behavioural RAM and fault injection
module tb_ram_bist_p;
  localparam int N = 256;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, mem_write_enable;
  logic [7:0]  fail_address, mem_address;
  logic [15:0] fail_expected, fail_actual, mem_data_out, mem_data_in;
  int total = 0;
  int bad = 0;
  logic [15:0] ram [N];
  logic [15:0] q;
  logic [7:0]  raddr_q;
  logic        rphase_q;
  int          wr_seen;
  logic        fault_on = 1'b0;
  logic [7:0]  fault_addr = '0;
  int          fault_phase = 2;
  logic [15:0] and_m = '1, or_m = '0, xor_m = '0;

  ram_bist_p #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_address(fail_address), .fail_expected(fail_expected), .fail_actual(fail_actual),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write_enable) ram[mem_address] <= mem_data_out;
    q        <= ram[mem_address];
    raddr_q  <= mem_address;
    rphase_q <= wr_seen >= 2 * N;
    wr_seen  <= !busy ? 0 : wr_seen + (mem_write_enable ? 1 : 0);
  end

  always_comb
    mem_data_in = (fault_on && raddr_q == fault_addr && (fault_phase == 2 || int'(rphase_q) == fault_phase))
                  ? (((q & and_m) | or_m) ^ xor_m) : q;

  task automatic run_bist(input bit noise, input bit peek, output int bcyc, output int wcyc);
    bit p0 = 0, p1 = 0;
    bcyc = 0;
    wcyc = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    while (busy && bcyc < 5000) begin
      if (peek && !p0 && wcyc == N && !mem_write_enable) begin
        p0 = 1;
        total += 2;
        if (ram[8'h2A] !== 16'h002A) begin bad++; $display("FAIL peek_wr0_2a got=%h exp=002a", ram[8'h2A]); end
        if (ram[8'hFF] !== 16'h00FF) begin bad++; $display("FAIL peek_wr0_ff got=%h exp=00ff", ram[8'hFF]); end
      end
      if (peek && !p1 && wcyc == 2 * N && !mem_write_enable) begin
        p1 = 1;
        total++;
        if (ram[8'h2A] !== 16'hFFD5) begin bad++; $display("FAIL peek_wr1_2a got=%h exp=ffd5", ram[8'h2A]); end
      end
      bcyc++;
      if (mem_write_enable) wcyc++;
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    if (peek && !(p0 && p1)) begin
      total++; bad++; $display("FAIL peek_reached got=%0d%0d exp=11", p0, p1);
    end
    if (bcyc >= 5000) begin
      total++; bad++; $display("FAIL run_timeout got=%0d exp=<5000", bcyc);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    total += 4;
    if ({busy, done, pass, mem_write_enable} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, pass, mem_write_enable}); end
    if (fail_address !== 8'h0) begin bad++; $display("FAIL reset_fail_addr got=%h exp=00", fail_address); end
    if ({fail_expected, fail_actual} !== 32'h0) begin bad++; $display("FAIL reset_fail_data got=%h exp=0", {fail_expected, fail_actual}); end
    if ({mem_address, mem_data_out} !== 24'h0) begin bad++; $display("FAIL reset_mem got=%h exp=0", {mem_address, mem_data_out}); end
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_clean(input bit noise, input string tag);
    int b, w;
    run_bist(noise, 1'b1, b, w);
    total += 4;
    if (b !== 4 * N + 2) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", tag, b, 4 * N + 2); end
    if (w !== 2 * N) begin bad++; $display("FAIL %s_we_cycles got=%0d exp=%0d", tag, w, 2 * N); end
    if ({done, pass} !== 2'b11) begin bad++; $display("FAIL %s_done_pass got=%b exp=11", tag, {done, pass}); end
    if ({fail_address, fail_expected, fail_actual} !== 40'h0) begin bad++; $display("FAIL %s_fail_clear got=%h exp=0", tag, {fail_address, fail_expected, fail_actual}); end
  endtask

  // model: compare of address a occurs in RD cycle a+1; busy drops right after it
  task automatic test_fault(input logic [7:0] a, input int ph, input logic [15:0] am, input logic [15:0] om,
                            input logic [15:0] xm, input string tag);
    int b, w, exp_b;
    logic [15:0] exp_d, exp_a;
    fault_on = 1'b1; fault_addr = a; fault_phase = ph; and_m = am; or_m = om; xor_m = xm;
    exp_d = (ph == 1) ? ~{8'h00, a} : {8'h00, a};
    exp_a = ((exp_d & am) | om) ^ xm;
    exp_b = (ph == 1 ? 3 * N + 1 : N) + int'(a) + 2;
    run_bist(1'b0, 1'b0, b, w);
    fault_on = 1'b0;
    total += 5;
    if (b !== exp_b) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", tag, b, exp_b); end
    if ({done, pass, mem_write_enable} !== 3'b100) begin bad++; $display("FAIL %s_done_pass_we got=%b exp=100", tag, {done, pass, mem_write_enable}); end
    if (fail_address !== a) begin bad++; $display("FAIL %s_fail_addr got=%h exp=%h", tag, fail_address, a); end
    if (fail_expected !== exp_d) begin bad++; $display("FAIL %s_fail_exp got=%h exp=%h", tag, fail_expected, exp_d); end
    if (fail_actual !== exp_a) begin bad++; $display("FAIL %s_fail_act got=%h exp=%h", tag, fail_actual, exp_a); end
  endtask

  task automatic test_random_faults;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      logic [15:0] m;
      a = 8'($urandom_range(0, N - 1));
      m = 16'(1) << $urandom_range(0, 15);
      test_fault(a, int'($urandom_range(0, 1)), 16'hFFFF, 16'h0000, m, "rand_fault");
    end
  endtask

  task automatic test_reset_mid;
    int n = 0, tgt;
    tgt = 2 * N + 1 + int'($urandom_range(1, 200));
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    while (n < tgt && busy) begin
      n++;
      @(negedge clock);
    end
    total += 2;
    if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL midreset_in_wr1 got=%b exp=1", mem_write_enable); end
    #2 reset_n = 1'b0;
    #1;
    if ({busy, done, pass, mem_write_enable, mem_address, mem_data_out} !== 28'h0) begin
      bad++; $display("FAIL midreset_outputs got=%h exp=0", {busy, done, pass, mem_write_enable, mem_address, mem_data_out});
    end
    @(negedge clock) reset_n = 1'b1;
    @(negedge clock);
    test_clean(1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_clean(1'b0, "clean");
    test_fault(8'h10, 2, 16'hFFFF, 16'h0008, 16'h0000, "stuck_bit3");
    test_fault(8'hFF, 1, 16'h0000, 16'h0000, 16'h0000, "inv_only");
    test_clean(1'b1, "restart_noise");
    test_clean(1'b0, "back_to_back");
    test_random_faults;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
